ulbf_data_sched: RTL and testbench
==================================

ULBF_DATA_SCHED -- requirements
Module: ulbf_data_sched

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of data masters sequenced.
REQ-002 Parameter TMO_WIDTH, default 24: width of the watchdog counter.
REQ-003 m_axis_clk  input  1: sole clock; all logic is on its rising edge.
REQ-004 m_axis_rst  input  1: reset, asynchronous and active-high.
REQ-005 start  input  1: run request pulse.
REQ-006 abort  input  1: run cancel pulse.
REQ-007 master_en  input  NUM_MASTERS: per-master enable mask.
REQ-008 niter_cfg  input  12: iterations per master run.
REQ-009 block_size_cfg  input  12: block size.
REQ-010 rollover_addr_cfg  input  16: RAM rollover address.
REQ-011 nrepeat_cfg  input  8: passes per run; 0 means continuous until abort.
REQ-012 stagger_cfg  input  8: idle cycles between successive go pulses.
REQ-013 timeout_cfg  input  TMO_WIDTH: per-pass watchdog limit in cycles; 0 disables it.
REQ-014 done_in  input  NUM_MASTERS: per-master done level.
REQ-015 go_out  output  NUM_MASTERS: one-cycle go pulse per master.
REQ-016 niter_out / block_size_out / rollover_addr_out  output  12/12/16: registered config, held stable while busy.
REQ-017 busy  output  1: high from LOAD through the final pass.
REQ-018 run_done  output  1: one-cycle pulse on normal completion.
REQ-019 timeout_err  output  1: sticky watchdog flag.
REQ-020 rep_count  output  8: number of completed passes.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, ISSUE, WAIT and NEXT.
REQ-022 In IDLE, start=1 with master_en!=0 and abort=0 SHALL go to LOAD. All other cases SHALL be ignored, including when abort and start are asserted together.
REQ-023 LOAD (1 cycle) SHALL capture the config inputs and master_en into en_q, clear rep_count and timeout_err, set busy=1, and go to ISSUE.
REQ-024 ISSUE entry SHALL clear done_seen, armed and the watchdog counter.
REQ-025 If stagger_cfg captured = 0, ISSUE SHALL pulse go_out=en_q in a single cycle.
REQ-026 If stagger_cfg captured > 0, ISSUE SHALL pulse the enabled masters in ascending index order, with exactly stagger cycles of idle between consecutive pulses.
REQ-027 ISSUE SHALL go to WAIT the cycle after the last go pulse.
REQ-028 armed[i] SHALL be set 2 cycles after go_out[i], so a stale done from the previous pass is masked.
REQ-029 done_seen[i] SHALL be set when done_in[i]=1 and armed[i]=1, in both ISSUE and WAIT.
REQ-030 WAIT SHALL go to NEXT when done_seen==en_q.
REQ-031 NEXT SHALL increment rep_count (8-bit, wraps 255->0).
REQ-032 From NEXT, if nrepeat_q==0 or rep_count+1<nrepeat_q, the FSM SHALL go to ISSUE.
REQ-033 Otherwise NEXT SHALL go to IDLE with run_done=1 for that one cycle and busy=0 from that cycle.
REQ-034 The watchdog SHALL count every cycle in ISSUE and WAIT.
REQ-035 When timeout_q!=0 and count==timeout_q, the block SHALL set timeout_err=1 and go to IDLE, with no run_done pulse.
REQ-036 When abort=1 in any non-IDLE state, the next state SHALL be IDLE; go_out SHALL be 0 from the abort cycle; and run_done SHALL NOT pulse.
REQ-037 start while busy SHALL be ignored.
REQ-038 done_in from masters with en_q=0 SHALL be ignored.
REQ-039 Config input changes while busy SHALL NOT affect the *_out outputs.

Reset
REQ-040 On m_axis_rst=1, the block SHALL immediately force state=IDLE and clear go_out, busy, run_done, timeout_err, rep_count, done_seen, armed, the watchdog and all *_out registers to 0.
REQ-041 Reset asserted mid-run SHALL behave as REQ-040, and no go pulse SHALL be emitted after reset deasserts until a new start.

Verification
REQ-042 en=0b1111, stagger=0, nrepeat=1, dones 10 cycles after go -> one go_out=0xF cycle; run_done once; rep_count=1; busy low on the run_done cycle.
REQ-043 en=0b0101, stagger=3, nrepeat=2 -> go[0] then go[2] 4 cycles apart, repeated for two passes; rep_count=2; go[1] and go[3] never pulse.
REQ-044 done_in held high from the previous run at the new start -> no pass completes until done_in deasserts and reasserts after arming.
REQ-045 timeout=50, master 1 never completes -> timeout_err=1 at cycle 50 of the pass; IDLE; no run_done; the next start clears timeout_err.
REQ-046 nrepeat=0, abort after 3 passes in WAIT -> IDLE next cycle; rep_count=3; no run_done; start and abort asserted together in IDLE -> ignored.
REQ-047 Reset asserted during ISSUE with stagger=5 -> all outputs 0 asynchronously; no further go pulses after release.

Source files
------------

// File: rtl/ulbf_data_sched.sv
// Run sequencer for the uplink beamformer data masters: issues (optionally staggered)
// go pulses, collects per-master done, repeats passes and guards each pass with a watchdog.
module ulbf_data_sched #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TMO_WIDTH   = 24
) (
    input  logic                   m_axis_clk,
    input  logic                   m_axis_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_MASTERS-1:0] master_en,
    input  logic [11:0]            niter_cfg,
    input  logic [11:0]            block_size_cfg,
    input  logic [15:0]            rollover_addr_cfg,
    input  logic [7:0]             nrepeat_cfg,
    input  logic [7:0]             stagger_cfg,
    input  logic [TMO_WIDTH-1:0]   timeout_cfg,
    input  logic [NUM_MASTERS-1:0] done_in,
    output logic [NUM_MASTERS-1:0] go_out,
    output logic [11:0]            niter_out,
    output logic [11:0]            block_size_out,
    output logic [15:0]            rollover_addr_out,
    output logic                   busy,
    output logic                   run_done,
    output logic                   timeout_err,
    output logic [7:0]             rep_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StNext
    } state_e;

    state_e state_q, state_d;

    logic [NUM_MASTERS-1:0] en_q, en_d;
    logic [NUM_MASTERS-1:0] pend_q, pend_d;
    logic [NUM_MASTERS-1:0] armed_q, armed_d;
    logic [NUM_MASTERS-1:0] go_dly_q, go_dly_d;
    logic [NUM_MASTERS-1:0] done_seen_q, done_seen_d;
    logic [7:0]             nrepeat_q, nrepeat_d;
    logic [7:0]             stagger_q, stagger_d;
    logic [7:0]             gap_q, gap_d;
    logic [7:0]             rep_q, rep_d;
    logic [TMO_WIDTH-1:0]   timeout_q, timeout_d;
    logic [TMO_WIDTH-1:0]   wd_q, wd_d;
    logic [11:0]            niter_q, niter_d;
    logic [11:0]            bsize_q, bsize_d;
    logic [15:0]            roll_q, roll_d;
    logic                   tmo_err_q, tmo_err_d;

    logic [NUM_MASTERS-1:0] go_sel;
    logic [NUM_MASTERS-1:0] go_vec;
    logic [TMO_WIDTH-1:0]   wd_cnt;
    logic [8:0]             rep_inc;
    logic                   in_pass;
    logic                   tmo_hit;
    logic                   last_pass;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        pend_d      = pend_q;
        done_seen_d = done_seen_q;
        nrepeat_d   = nrepeat_q;
        stagger_d   = stagger_q;
        gap_d       = gap_q;
        rep_d       = rep_q;
        timeout_d   = timeout_q;
        wd_d        = wd_q;
        niter_d     = niter_q;
        bsize_d     = bsize_q;
        roll_d      = roll_q;
        tmo_err_d   = tmo_err_q;
        go_vec      = '0;

        // Zero stagger fires every pending master at once, otherwise only the lowest one.
        go_sel    = (stagger_q == 8'd0) ? pend_q : (pend_q & (~pend_q + NUM_MASTERS'(1)));
        wd_cnt    = wd_q + TMO_WIDTH'(1);
        rep_inc   = {1'b0, rep_q} + 9'd1;
        last_pass = (nrepeat_q != 8'd0) && (rep_inc >= {1'b0, nrepeat_q});
        in_pass   = (state_q == StIssue) || (state_q == StWait);
        // A pass is cut off after exactly timeout_q cycles spent in ISSUE/WAIT.
        tmo_hit   = in_pass && (timeout_q != '0) && (wd_cnt == timeout_q);

        // Two-cycle arm delay masks a done level left over from the previous pass.
        armed_d   = armed_q | go_dly_q;

        unique case (state_q)
            StIdle: begin
                if (start && (|master_en) && !abort) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                en_d      = master_en;
                nrepeat_d = nrepeat_cfg;
                stagger_d = stagger_cfg;
                timeout_d = timeout_cfg;
                niter_d   = niter_cfg;
                bsize_d   = block_size_cfg;
                roll_d    = rollover_addr_cfg;
                rep_d     = '0;
                tmo_err_d = 1'b0;
                state_d   = StIssue;
            end
            StIssue: begin
                wd_d        = wd_cnt;
                done_seen_d = done_seen_q | (done_in & armed_q & en_q);
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    go_vec = go_sel;
                    pend_d = pend_q & ~go_sel;
                    gap_d  = stagger_q;
                    if ((pend_q & ~go_sel) == '0) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wd_d        = wd_cnt;
                done_seen_d = done_seen_q | (done_in & armed_q & en_q);
                if (done_seen_q == en_q) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                rep_d   = rep_inc[7:0];
                state_d = last_pass ? StIdle : StIssue;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tmo_hit) begin
            state_d   = StIdle;
            tmo_err_d = 1'b1;
            go_vec    = '0;
        end

        // Abort wins over everything, including a watchdog expiry in the same cycle.
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            rep_d     = rep_q;
            tmo_err_d = tmo_err_q;
            go_vec    = '0;
        end

        if ((state_d == StIssue) && (state_q != StIssue)) begin
            pend_d      = en_d;
            gap_d       = '0;
            armed_d     = '0;
            done_seen_d = '0;
            wd_d        = '0;
        end
    end

    assign go_dly_d = go_vec;

    always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
        if (m_axis_rst) begin
            state_q     <= StIdle;
            en_q        <= '0;
            pend_q      <= '0;
            armed_q     <= '0;
            go_dly_q    <= '0;
            done_seen_q <= '0;
            nrepeat_q   <= '0;
            stagger_q   <= '0;
            gap_q       <= '0;
            rep_q       <= '0;
            timeout_q   <= '0;
            wd_q        <= '0;
            niter_q     <= '0;
            bsize_q     <= '0;
            roll_q      <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            armed_q     <= armed_d;
            go_dly_q    <= go_dly_d;
            done_seen_q <= done_seen_d;
            nrepeat_q   <= nrepeat_d;
            stagger_q   <= stagger_d;
            gap_q       <= gap_d;
            rep_q       <= rep_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
            niter_q     <= niter_d;
            bsize_q     <= bsize_d;
            roll_q      <= roll_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign go_out            = go_vec;
    assign busy              = (state_q != StIdle) && !((state_q == StNext) && last_pass);
    assign run_done          = (state_q == StNext) && last_pass && !abort;
    assign timeout_err       = tmo_err_q;
    assign rep_count         = rep_q;
    assign niter_out         = niter_q;
    assign block_size_out    = bsize_q;
    assign rollover_addr_out = roll_q;

endmodule

// File: tb/tb_ulbf_data_sched.sv
// Directed bench for ulbf_data_sched: expected go pulses are queued at each start and
// matched as the DUT emits them; a behavioural master model answers each go with done.
module tb_ulbf_data_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  master_en;
    logic [11:0] niter_cfg;
    logic [11:0] block_size_cfg;
    logic [15:0] rollover_addr_cfg;
    logic [7:0]  nrepeat_cfg;
    logic [7:0]  stagger_cfg;
    logic [23:0] timeout_cfg;
    logic [3:0]  done_in;
    logic [3:0]  go_out;
    logic [11:0] niter_out;
    logic [11:0] block_size_out;
    logic [15:0] rollover_addr_out;
    logic        busy;
    logic        run_done;
    logic        timeout_err;
    logic [7:0]  rep_count;

    ulbf_data_sched #(
        .NUM_MASTERS(4),
        .TMO_WIDTH  (24)
    ) dut (
        .m_axis_clk       (clk),
        .m_axis_rst       (rst),
        .start            (start),
        .abort            (abort),
        .master_en        (master_en),
        .niter_cfg        (niter_cfg),
        .block_size_cfg   (block_size_cfg),
        .rollover_addr_cfg(rollover_addr_cfg),
        .nrepeat_cfg      (nrepeat_cfg),
        .stagger_cfg      (stagger_cfg),
        .timeout_cfg      (timeout_cfg),
        .done_in          (done_in),
        .go_out           (go_out),
        .niter_out        (niter_out),
        .block_size_out   (block_size_out),
        .rollover_addr_out(rollover_addr_out),
        .busy             (busy),
        .run_done         (run_done),
        .timeout_err      (timeout_err),
        .rep_count        (rep_count)
    );

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } go_ev_t;

    go_ev_t     exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         rd_cnt = 0;
    int         lat = 10;
    logic [3:0] stuck = '0;
    logic       late_drop = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    // Master model: done drops after go (one cycle late if late_drop) and rises lat cycles after go.
    initial begin
        int         cnt[4];
        logic [3:0] g;
        logic [3:0] drop_pend;
        done_in   = '0;
        drop_pend = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            g = go_out;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (drop_pend[i]) begin
                    done_in[i]   = 1'b0;
                    drop_pend[i] = 1'b0;
                end
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0 && !stuck[i]) done_in[i] = 1'b1;
                end
                if (g[i]) begin
                    if (late_drop) drop_pend[i] = 1'b1;
                    else done_in[i] = 1'b0;
                    cnt[i] = lat - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples outputs mid-cycle, then advances to 1 time unit after the next rising edge.
    task automatic tick();
        go_ev_t e;
        @(negedge clk);
        if (go_out != '0) begin
            if (exp_q.size() == 0) begin
                check("go_unexpected", {28'd0, go_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("go_vec", {28'd0, go_out}, {28'd0, e.vec});
                check("go_cycle", cyc, e.cyc);
            end
        end
        if (run_done) rd_cnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_cfg(input logic [3:0] en, input int stag, input int nrep, input int tmo);
        master_en   = en;
        stagger_cfg = 8'(stag);
        nrepeat_cfg = 8'(nrep);
        timeout_cfg = 24'(tmo);
    endtask

    task automatic do_start(output int s);
        s     = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_pass(input int base, input logic [3:0] en, input int stag,
                             output int last);
        int c;
        c = base;
        last = base;
        if (stag == 0) begin
            exp_q.push_back('{cyc: base, vec: en});
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    exp_q.push_back('{cyc: c, vec: 4'(1 << i)});
                    last = c;
                    c = c + stag + 1;
                end
            end
        end
    endtask

    task automatic wait_run_done(input int exp_c, input string tag);
        int n;
        n = 0;
        while (!run_done && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, {31'd0, run_done}, 32'd1);
        if (run_done) begin
            check({tag, "_cycle"}, cyc, exp_c);
            check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int s;
        int last;
        int rd0;
        int b;
        rst               = 1'b1;
        start             = 1'b0;
        abort             = 1'b0;
        master_en         = '0;
        niter_cfg         = '0;
        block_size_cfg    = '0;
        rollover_addr_cfg = '0;
        nrepeat_cfg       = '0;
        stagger_cfg       = '0;
        timeout_cfg       = '0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_go", {28'd0, go_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_run_done", {31'd0, run_done}, 32'd0);
        check("rst_tmo", {31'd0, timeout_err}, 32'd0);
        check("rst_rep", {24'd0, rep_count}, 32'd0);
        check("rst_niter", {20'd0, niter_out}, 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // All four masters, no stagger, single pass; start and config changes while busy
        niter_cfg         = 12'h123;
        block_size_cfg    = 12'h040;
        rollover_addr_cfg = 16'hBEEF;
        lat = 10;
        set_cfg(4'hF, 0, 1, 0);
        rd0 = rd_cnt;
        do_start(s);
        push_pass(s + 2, 4'hF, 0, last);
        check("t1_load_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1_niter", {20'd0, niter_out}, 32'h123);
        check("t1_bsize", {20'd0, block_size_out}, 32'h040);
        check("t1_roll", {16'd0, rollover_addr_out}, 32'hBEEF);
        niter_cfg         = 12'hFFF;
        block_size_cfg    = 12'hFFF;
        rollover_addr_cfg = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run_done(last + lat + 2, "t1_done");
        tick();
        check("t1_rep", {24'd0, rep_count}, 32'd1);
        check("t1_runs", rd_cnt - rd0, 32'd1);
        check("t1_niter_held", {20'd0, niter_out}, 32'h123);
        check("t1_roll_held", {16'd0, rollover_addr_out}, 32'hBEEF);
        ticks(3);

        // Masters 0 and 2, stagger 3, two passes; masters 1 and 3 hold done high throughout
        set_cfg(4'h5, 3, 2, 0);
        rd0 = rd_cnt;
        do_start(s);
        push_pass(s + 2, 4'h5, 3, last);
        push_pass(last + lat + 3, 4'h5, 3, last);
        goto(s + 20);
        check("t2_rep_mid", {24'd0, rep_count}, 32'd1);
        check("t2_busy_mid", {31'd0, busy}, 32'd1);
        wait_run_done(last + lat + 2, "t2_done");
        tick();
        check("t2_rep", {24'd0, rep_count}, 32'd2);
        check("t2_runs", rd_cnt - rd0, 32'd1);
        ticks(3);

        // Done still high from the previous run and dropped late: must not end the pass
        late_drop = 1'b1;
        lat = 20;
        set_cfg(4'hF, 0, 1, 0);
        do_start(s);
        push_pass(s + 2, 4'hF, 0, last);
        wait_run_done(last + lat + 2, "t3_done");
        tick();
        late_drop = 1'b0;
        ticks(3);

        // Watchdog: master 1 never completes
        lat = 10;
        stuck = 4'b0010;
        set_cfg(4'h3, 0, 1, 50);
        rd0 = rd_cnt;
        do_start(s);
        push_pass(s + 2, 4'h3, 0, last);
        goto(last + 49);
        check("t4_tmo_before", {31'd0, timeout_err}, 32'd0);
        check("t4_busy_before", {31'd0, busy}, 32'd1);
        tick();
        check("t4_tmo", {31'd0, timeout_err}, 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);
        ticks(3);
        check("t4_tmo_sticky", {31'd0, timeout_err}, 32'd1);
        check("t4_no_done", rd_cnt - rd0, 32'd0);
        stuck = 4'b0000;
        set_cfg(4'h3, 0, 1, 0);
        do_start(s);
        push_pass(s + 2, 4'h3, 0, last);
        tick();
        check("t4_tmo_cleared", {31'd0, timeout_err}, 32'd0);
        wait_run_done(last + lat + 2, "t4_rerun");
        ticks(3);

        // Continuous passes, abort in WAIT of the fourth pass
        lat = 5;
        set_cfg(4'h1, 0, 0, 0);
        rd0 = rd_cnt;
        do_start(s);
        b = s + 2;
        for (int k = 0; k < 4; k++) push_pass(b + 8 * k, 4'h1, 0, last);
        goto(b + 27);
        check("t5_rep_pre", {24'd0, rep_count}, 32'd3);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        #1;
        check("t5_abort_no_done", {31'd0, run_done}, 32'd0);
        tick();
        abort = 1'b0;
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_rep", {24'd0, rep_count}, 32'd3);
        ticks(4);
        check("t5_no_done", rd_cnt - rd0, 32'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_sa_ignored", {31'd0, busy}, 32'd0);
        tick();
        check("t5_sa_still_idle", {31'd0, busy}, 32'd0);
        ticks(5);

        // Abort between staggered pulses: the pulse due in the abort cycle is suppressed
        lat = 10;
        set_cfg(4'hF, 2, 1, 0);
        do_start(s);
        exp_q.push_back('{cyc: s + 2, vec: 4'h1});
        goto(s + 5);
        abort = 1'b1;
        #1;
        check("t6_go_abort", {28'd0, go_out}, 32'd0);
        tick();
        abort = 1'b0;
        check("t6_idle", {31'd0, busy}, 32'd0);
        ticks(10);

        // Reset in ISSUE with stagger 5, in the cycle of the second go
        niter_cfg         = 12'h5A5;
        block_size_cfg    = 12'h0A5;
        rollover_addr_cfg = 16'h1234;
        set_cfg(4'hF, 5, 1, 0);
        do_start(s);
        exp_q.push_back('{cyc: s + 2, vec: 4'h1});
        goto(s + 8);
        check("t7_busy_pre", {31'd0, busy}, 32'd1);
        check("t7_niter_pre", {20'd0, niter_out}, 32'h5A5);
        rst = 1'b1;
        #1;
        check("t7_go", {28'd0, go_out}, 32'd0);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_run_done", {31'd0, run_done}, 32'd0);
        check("t7_tmo", {31'd0, timeout_err}, 32'd0);
        check("t7_rep", {24'd0, rep_count}, 32'd0);
        check("t7_niter", {20'd0, niter_out}, 32'd0);
        check("t7_bsize", {20'd0, block_size_out}, 32'd0);
        check("t7_roll", {16'd0, rollover_addr_out}, 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(40);
        check("t7_idle_after", {31'd0, busy}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
